// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types, constants and the M-counter field encoder
// for the PLL reconfiguration controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_UPDATE,
    S_WAIT_DONE,
    S_PLL_RST,
    S_WAIT_LOCK,
    S_FAIL
  } state_t;

  localparam int M_FIELD_W  = 18;
  localparam int SYNC_DEPTH = 2;
  localparam int ARESET_W   = 4;

  // {bypass, odd, high, low}; high takes the extra count for odd factors
  function automatic logic [M_FIELD_W-1:0] encode_m(
    input logic [7:0] m
  );
    logic [7:0] hi;
    logic [7:0] lo;
    lo = {1'b0, m[7:1]};
    hi = lo + {7'd0, m[0]};
    return {m == 8'd1, m[0], hi, lo};
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_if.sv
// pll_reconfig_ctrl_if: frequency-change request handshake between the
// command decoder (master) and the PLL reconfiguration controller (slave).
interface pll_reconfig_ctrl_if;

  logic       req_valid;
  logic [7:0] req_mult;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_mult,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mult,
    output req_ready
  );

endinterface

// File: rtl/pll_scan_shifter.sv
// pll_scan_shifter: loads a full scan image and shifts it MSB first,
// generating scanclk at clk/2 with data changing on the falling phase.
module pll_scan_shifter #(
  parameter int SCAN_LEN = 144
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SCAN_LEN-1:0] image,
  input  logic                start,
  output logic                done,
  output logic                scanclk,
  output logic                scanclkena,
  output logic                scandata
);

  localparam int CW = $clog2(SCAN_LEN);

  logic [SCAN_LEN-1:0] sreg;
  logic [CW-1:0]       bit_cnt;
  logic                active;
  logic                ph;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      active     <= 1'b0;
      ph         <= 1'b0;
      done       <= 1'b0;
      scanclk    <= 1'b0;
      scanclkena <= 1'b0;
      scandata   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load)
        sreg <= image;
      if (start) begin
        active  <= 1'b1;
        ph      <= 1'b0;
        bit_cnt <= '0;
      end else if (active) begin
        if (!ph) begin
          scanclk    <= 1'b0;
          scanclkena <= 1'b1;
          scandata   <= sreg[SCAN_LEN-1];
          sreg       <= {sreg[SCAN_LEN-2:0], 1'b0};
          ph         <= 1'b1;
        end else begin
          scanclk <= 1'b1;
          ph      <= 1'b0;
          if (bit_cnt == CW'(SCAN_LEN - 1)) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end else begin
        scanclk    <= 1'b0;
        scanclkena <= 1'b0;
        scandata   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: run-time clk0 multiply control for the hashing PLL.
// Define PLL_LOCK_WATCH_EN to re-lock automatically when lock drops in IDLE.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int                  SCAN_LEN     = 144,
  parameter int                  M_POS        = 36,
  parameter logic [SCAN_LEN-1:0] BASE_IMAGE   = '0,
  parameter int                  INIT_MULT    = 5,
  parameter int                  M_MIN        = 2,
  parameter int                  M_MAX        = 40,
  parameter int                  LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  pll_reconfig_ctrl_if.slave  req,
  output logic                scanclk,
  output logic                scanclkena,
  output logic                scandata,
  output logic                configupdate,
  input  logic                scandone,
  output logic                pll_areset,
  input  logic                locked,
  output logic [7:0]          cur_mult,
  output logic                busy,
  output logic                err_range,
  output logic                err_fail
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  state_t              state;
  state_t              state_nx;
  logic [7:0]          target;
  logic [7:0]          cur_mult_r;
  logic                fallback;
  logic [CW-1:0]       cnt;
  logic                cnt_run;
  logic                err_range_r;
  logic [SYNC_DEPTH-1:0] lock_sync;
  logic                lock_s;
  logic                in_range;
  logic                launch;
  logic [7:0]          launch_m;
  logic [SCAN_LEN-1:0] image;
  logic                shift_done;
  logic                watch_hit;

  assign lock_s   = lock_sync[SYNC_DEPTH-1];
  assign in_range = req.req_mult >= 8'(M_MIN) &&
                    req.req_mult <= 8'(M_MAX);

  always_ff @(posedge clk) begin
    if (reset)
      lock_sync <= '0;
    else
      lock_sync <= {lock_sync[SYNC_DEPTH-2:0], locked};
  end

`ifdef PLL_LOCK_WATCH_EN
  logic [3:0] watch_cnt;

  assign watch_hit = !lock_s && watch_cnt == 4'hF;

  always_ff @(posedge clk) begin
    if (reset || state != S_IDLE || lock_s)
      watch_cnt <= '0;
    else if (!watch_hit)
      watch_cnt <= watch_cnt + 4'd1;
  end
`else
  assign watch_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    launch_m = req.req_mult;
    unique case (state)
      S_IDLE: begin
        if (req.req_valid) begin
          if (in_range && req.req_mult != cur_mult_r) begin
            state_nx = S_SHIFT;
            launch   = 1'b1;
          end
        end else if (watch_hit) begin
          state_nx = S_PLL_RST;
        end
      end
      S_SHIFT:
        if (shift_done)
          state_nx = S_UPDATE;
      S_UPDATE:
        state_nx = S_WAIT_DONE;
      S_WAIT_DONE:
        if (scandone)
          state_nx = S_PLL_RST;
      S_PLL_RST:
        if (cnt == CW'(ARESET_W - 1))
          state_nx = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = S_IDLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (fallback) begin
            state_nx = S_FAIL;
          end else begin
            state_nx = S_SHIFT;
            launch   = 1'b1;
            launch_m = cur_mult_r;
          end
        end
      end
      S_FAIL:
        state_nx = S_FAIL;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req.req_ready = state == S_IDLE;
    busy          = state != S_IDLE;
    configupdate  = state == S_UPDATE;
    pll_areset    = state == S_PLL_RST;
    err_fail      = state == S_FAIL;
  end

  assign cnt_run = state_nx == state &&
                   (state == S_PLL_RST || state == S_WAIT_LOCK);

  always_ff @(posedge clk) begin
    if (reset) begin
      target      <= 8'(INIT_MULT);
      cur_mult_r  <= 8'(INIT_MULT);
      fallback    <= 1'b0;
      cnt         <= '0;
      err_range_r <= 1'b0;
    end else begin
      err_range_r <= state == S_IDLE && req.req_valid && !in_range;
      cnt         <= cnt_run ? cnt + CW'(1) : '0;
      if (state == S_IDLE && state_nx != S_IDLE) begin
        target   <= launch ? req.req_mult : cur_mult_r;
        fallback <= 1'b0;
      end
      if (state == S_WAIT_LOCK && launch) begin
        target   <= cur_mult_r;
        fallback <= 1'b1;
      end
      if (state == S_WAIT_LOCK && lock_s)
        cur_mult_r <= target;
    end
  end

  assign cur_mult  = cur_mult_r;
  assign err_range = err_range_r;

  // only the M field changes; everything else comes from the base image
  always_comb begin
    image = BASE_IMAGE;
    image[M_POS +: M_FIELD_W] = encode_m(launch_m);
  end

  pll_scan_shifter #(
    .SCAN_LEN (SCAN_LEN)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (launch),
    .image      (image),
    .start      (launch),
    .done       (shift_done),
    .scanclk    (scanclk),
    .scanclkena (scanclkena),
    .scandata   (scandata)
  );

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl: scoreboard bench for pll_reconfig_ctrl with a
// behavioural PLL model driving scandone and locked.
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       scanclk;
  logic       scanclkena;
  logic       scandata;
  logic       configupdate;
  logic       scandone;
  logic       pll_areset;
  logic       locked;
  logic [7:0] cur_mult;
  logic       busy;
  logic       err_range;
  logic       err_fail;

  pll_reconfig_ctrl_if rif();

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .LOCK_TIMEOUT (1000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (rif),
    .scanclk      (scanclk),
    .scanclkena   (scanclkena),
    .scandata     (scandata),
    .configupdate (configupdate),
    .scandone     (scandone),
    .pll_areset   (pll_areset),
    .locked       (locked),
    .cur_mult     (cur_mult),
    .busy         (busy),
    .err_range    (err_range),
    .err_fail     (err_fail)
  );

  int tests = 0;
  int fails = 0;

  logic [17:0] exp_scan[$];
  int          exp_done[$];
  int          exp_err[$];
  int          exp_fail[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name,
                           input logic [143:0] act,
                           input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic no_exp(input string name);
    tests++;
    fails++;
    $display("FAIL %s: output seen with no expectation queued", name);
  endtask

  // PLL model: scandone 6 cycles after configupdate, locked 100 cycles
  // after areset release unless fail_budget says this attempt never locks
  int fail_budget = 0;
  int done_dly    = 0;
  int rel_cnt     = 0;
  bit armed       = 1'b0;
  bit ar_prev     = 1'b0;

  always @(negedge clk) begin
    if (configupdate) begin
      done_dly = 6;
      locked   = 1'b0;
    end else if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0)
        scandone = 1'b1;
    end else begin
      scandone = 1'b0;
    end
    if (pll_areset) begin
      locked  = 1'b0;
      rel_cnt = 0;
      if (!ar_prev) begin
        if (fail_budget > 0) begin
          fail_budget--;
          armed = 1'b0;
        end else begin
          armed = 1'b1;
        end
      end
    end else if (armed) begin
      rel_cnt++;
      if (rel_cnt >= 100) begin
        locked = 1'b1;
        armed  = 1'b0;
      end
    end
    ar_prev = pll_areset;
  end

  // monitor
  int           nbits      = 0;
  int           ena_cnt    = 0;
  int           cu_len     = 0;
  int           er_len     = 0;
  int           rise_total = 0;
  logic         prev_sclk  = 1'b0;
  logic         prev_busy  = 1'b0;
  logic         prev_fail  = 1'b0;
  logic [143:0] cap        = '0;
  logic [17:0]  fld;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      nbits     = 0;
      ena_cnt   = 0;
      cu_len    = 0;
      er_len    = 0;
      cap       = '0;
      prev_sclk = 1'b0;
    end else begin
      if (scanclkena)
        ena_cnt++;
      if (scanclk && !prev_sclk) begin
        rise_total++;
        if (scanclkena) begin
          cap = {cap[142:0], scandata};
          nbits++;
        end
      end
      prev_sclk = scanclk;
      if (configupdate) begin
        cu_len++;
        if (cu_len == 1) begin
          if (exp_scan.size() == 0) begin
            no_exp("scan");
          end else begin
            fld = exp_scan.pop_front();
            check("scan_bits", nbits, 144);
            check("shift_cycles", ena_cnt, 288);
            check("m_field", int'(cap[53:36]), int'(fld));
            check_img("scan_image", cap, {126'd0, fld} << 36);
          end
          nbits   = 0;
          ena_cnt = 0;
        end
      end else if (cu_len != 0) begin
        check("cfgupd_width", cu_len, 1);
        cu_len = 0;
      end
      if (err_range) begin
        er_len++;
        if (er_len == 1) begin
          if (exp_err.size() == 0)
            no_exp("err_range");
          else
            check("err_cur_mult", int'(cur_mult), exp_err.pop_front());
        end
      end else if (er_len != 0) begin
        check("err_range_width", er_len, 1);
        er_len = 0;
      end
      if (prev_busy && !busy) begin
        if (exp_done.size() == 0)
          no_exp("done");
        else
          check("done_cur_mult", int'(cur_mult), exp_done.pop_front());
      end
      if (err_fail && !prev_fail) begin
        if (exp_fail.size() == 0)
          no_exp("fail");
        else
          check("fail_ready", int'(rif.req_ready), exp_fail.pop_front());
      end
    end
    prev_busy = busy;
    prev_fail = err_fail;
  end

  task automatic do_req(input logic [7:0] m);
    @(negedge clk);
    rif.req_valid = 1'b1;
    rif.req_mult  = m;
    @(negedge clk);
    rif.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic reconf(input logic [7:0] m, input logic [17:0] f);
    exp_scan.push_back(f);
    exp_done.push_back(int'(m));
    do_req(m);
    check("ready_drop", int'(rif.req_ready), 0);
    check("busy_rise", int'(busy), 1);
    wait_idle(5000);
    check("cur_mult", int'(cur_mult), int'(m));
  endtask

  task automatic bad_req(input logic [7:0] m, input int cur);
    int r0;
    r0 = rise_total;
    exp_err.push_back(cur);
    do_req(m);
    repeat (20) @(negedge clk);
    check("err_no_scan", rise_total - r0, 0);
    check("err_keep_mult", int'(cur_mult), cur);
    check("err_pulse_end", int'(err_range), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    reset         = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_mult  = 8'd0;
    scandone      = 1'b0;
    locked        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_cur_mult", int'(cur_mult), 5);
    check("rst_ready", int'(rif.req_ready), 1);
    check("rst_strobes", int'({err_range, err_fail, configupdate,
          pll_areset, scanclk, scanclkena, scandata, busy}), 0);

    reconf(8'd8, 18'h00404);
    reconf(8'd7, 18'h10403);
    bad_req(8'd41, 7);
    bad_req(8'd1, 7);

    do_req(8'd7);
    check("noop_busy", int'(busy), 0);
    check("noop_ready", int'(rif.req_ready), 1);
    repeat (5) @(negedge clk);
    check("noop_mult", int'(cur_mult), 7);

    reconf(8'd40, 18'h01414);

    do_reset();
    check("rst2_mult", int'(cur_mult), 5);
    fail_budget = 1;
    exp_scan.push_back(18'h00606);
    exp_scan.push_back(18'h10302);
    exp_done.push_back(5);
    do_req(8'd12);
    wait_idle(6000);
    check("fb_mult", int'(cur_mult), 5);
    check("fb_no_fail", int'(err_fail), 0);

    fail_budget = 2;
    exp_scan.push_back(18'h00606);
    exp_scan.push_back(18'h10302);
    exp_fail.push_back(0);
    do_req(8'd12);
    n = 0;
    while (!err_fail && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("fail_set", int'(err_fail), 1);
    repeat (5) @(negedge clk);
    check("fail_ready", int'(rif.req_ready), 0);
    check("fail_busy", int'(busy), 1);
    check("fail_mult", int'(cur_mult), 5);

    do_reset();
    check("rst3_fail", int'(err_fail), 0);
    check("rst3_ready", int'(rif.req_ready), 1);

    do_req(8'd9);
    n = 0;
    while (nbits < 60 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bit60_reached", nbits, 60);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_outs", int'({scanclk, scanclkena, scandata,
          configupdate, pll_areset, busy, err_range, err_fail}), 0);
    check("mid_rst_ready", int'(rif.req_ready), 1);
    check("mid_rst_mult", int'(cur_mult), 5);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    reconf(8'd10, 18'h00505);

    repeat (5) @(negedge clk);
    check("scan_q_empty", exp_scan.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
    check("err_q_empty", exp_err.size(), 0);
    check("fail_q_empty", exp_fail.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
